// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse letter sequencer.
package morse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_GAP,
    ST_DONE
  } state_t;

  // pattern bit i is symbol i (1 = dash, 0 = dot); symbol 0 is sent first
  typedef struct packed {
    logic [3:0] pattern;
    logic [2:0] length;
  } code_t;

  localparam int DASH_UNITS_DEF = 3;

  localparam code_t CODE_A = '{pattern: 4'b0010, length: 3'd2};  // .-
  localparam code_t CODE_B = '{pattern: 4'b0001, length: 3'd4};  // -...
  localparam code_t CODE_C = '{pattern: 4'b0101, length: 3'd4};  // -.-.
  localparam code_t CODE_D = '{pattern: 4'b0001, length: 3'd3};  // -..
  localparam code_t CODE_E = '{pattern: 4'b0000, length: 3'd1};  // .
  localparam code_t CODE_F = '{pattern: 4'b0100, length: 3'd4};  // ..-.
  localparam code_t CODE_G = '{pattern: 4'b0011, length: 3'd3};  // --.
  localparam code_t CODE_H = '{pattern: 4'b0000, length: 3'd4};  // ....

  function automatic code_t code_lookup(input logic [2:0] letter);
    code_t c;
    case (letter)
      3'd0:    c = CODE_A;
      3'd1:    c = CODE_B;
      3'd2:    c = CODE_C;
      3'd3:    c = CODE_D;
      3'd4:    c = CODE_E;
      3'd5:    c = CODE_F;
      3'd6:    c = CODE_G;
      default: c = CODE_H;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/unit_timer.sv
// Loadable down-counter; holds at zero instead of wrapping.
module unit_timer #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expired
);

  logic [W-1:0] count;

  // load wins over counting; stop at zero so a phase can never wrap
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign expired = (count == '0);

endmodule

// File: rtl/morse_sequencer.sv
// Sends one letter (A..H) as Morse code on a lamp output.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for start; lamp off
// ON    | lamp on for one dot (U) or one dash (DASH_UNITS*U)
// GAP   | lamp off for U between symbols
// DONE  | single cycle, done pulse, then back to IDLE
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int DASH_UNITS  = DASH_UNITS_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] letter,
  output logic       light,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(DASH_UNITS * TICK_CYCLES + 1);
  // the timer counts load..0 inclusive, so a phase of N cycles loads N-1
  localparam logic [CW-1:0] DOT_LOAD  = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LOAD = CW'(DASH_UNITS * TICK_CYCLES - 1);

  state_t          state;
  code_t           code_q;
  code_t           code_in;
  logic [1:0]      sym_idx;
  logic            last_sym;
  logic            timer_load;
  logic [CW-1:0]   timer_value;
  logic            expired;

  assign code_in  = code_lookup(letter);
  assign last_sym = ({1'b0, sym_idx} + 3'd1) >= code_q.length;

  unit_timer #(.W(CW)) u_timer (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .expired    (expired)
  );

  // reload the timer on every phase entry with that phase's duration
  always_comb begin
    timer_load  = 1'b0;
    timer_value = DOT_LOAD;
    case (state)
      ST_IDLE: begin
        if (start && !abort) begin
          timer_load  = 1'b1;
          timer_value = code_in.pattern[0] ? DASH_LOAD : DOT_LOAD;
        end
      end
      ST_ON: begin
        if (!abort && expired && !last_sym) timer_load = 1'b1;
      end
      ST_GAP: begin
        if (!abort && expired) begin
          timer_load  = 1'b1;
          timer_value = code_q.pattern[sym_idx] ? DASH_LOAD : DOT_LOAD;
        end
      end
      default: ;
    endcase
  end

  // sequencing FSM with registered lamp/busy/done outputs
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      code_q  <= '0;
      sym_idx <= '0;
      light   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            code_q  <= code_in;
            sym_idx <= '0;
            state   <= ST_ON;
            light   <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_ON: begin
          if (abort) begin
            state <= ST_IDLE;
            light <= 1'b0;
            busy  <= 1'b0;
          end else if (expired) begin
            light <= 1'b0;
            if (last_sym) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state   <= ST_GAP;
              sym_idx <= sym_idx + 2'd1;
            end
          end
        end
        ST_GAP: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (expired) begin
            state <= ST_ON;
            light <= 1'b1;
          end
        end
        ST_DONE: begin
          // abort here is ignored: the done pulse is already out
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          light <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer with U=4 cycles, dash=3 units.
module tb_morse_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [2:0] letter;
  logic       light;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  morse_sequencer #(.TICK_CYCLES(4), .DASH_UNITS(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .start    (start),
    .abort    (abort),
    .letter   (letter),
    .light    (light),
    .busy     (busy),
    .done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // check one cycle (numbered from the start edge) then advance to the next
  task automatic cyc(input string tag, input int c, input logic [63:0] mask,
                     input int busy_last, input int done_c);
    @(negedge CLOCK_50);
    chk($sformatf("%s c%0d light", tag, c), light, mask[c]);
    chk($sformatf("%s c%0d busy", tag, c), busy, (c <= busy_last));
    chk($sformatf("%s c%0d done", tag, c), done, (c == done_c));
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic kick(input logic [2:0] l);
    letter = l;
    start  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
  endtask

  task automatic run(input string tag, input logic [2:0] l, input logic [63:0] mask,
                     input int last);
    kick(l);
    for (int c = 1; c <= last + 1; c++) cyc(tag, c, mask, last, last);
  endtask

  logic [63:0] mask_b;
  logic [63:0] mask_g;

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    abort  = 1'b0;
    letter = 3'd0;
    mask_b = rng(1, 12) | rng(17, 20) | rng(25, 28) | rng(33, 36);
    mask_g = rng(1, 12) | rng(17, 28) | rng(33, 36);

    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst light", light, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    reset = 1'b0;

    // first start right after reset release is honoured
    run("A", 3'd0, rng(1, 4) | rng(9, 20), 21);
    run("E", 3'd4, rng(1, 4), 5);
    run("H", 3'd7, rng(1, 4) | rng(9, 12) | rng(17, 20) | rng(25, 28), 29);
    run("D", 3'd3, rng(1, 12) | rng(17, 20) | rng(25, 28), 29);
    run("F", 3'd5, rng(1, 4) | rng(9, 12) | rng(17, 28) | rng(33, 36), 37);

    // letter change and start re-pulse while busy are ignored
    kick(3'd2);
    for (int c = 1; c <= 46; c++) begin
      if (c == 6) begin
        letter = 3'd4;
        start  = 1'b1;
      end
      cyc("C", c, rng(1, 12) | rng(17, 20) | rng(25, 36) | rng(41, 44), 45, 45);
      start = 1'b0;
    end

    // asynchronous reset mid-transmission
    kick(3'd1);
    for (int c = 1; c <= 6; c++) cyc("Bpre", c, mask_b, 37, 37);
    #2;
    chk("B c7 light before reset", light, 1'b1);
    reset = 1'b1;
    #1;
    chk("B async light", light, 1'b0);
    chk("B async busy", busy, 1'b0);
    chk("B async done", done, 1'b0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    chk("B held done", done, 1'b0);
    reset = 1'b0;
    run("B", 3'd1, mask_b, 37);

    // abort in IDLE beats start
    letter = 3'd4;
    start  = 1'b1;
    abort  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge CLOCK_50);
    chk("idle abort busy", busy, 1'b0);
    chk("idle abort light", light, 1'b0);
    @(posedge CLOCK_50);
    #1;

    // abort during a gap
    kick(3'd6);
    for (int c = 1; c <= 16; c++) begin
      if (c == 14) abort = 1'b1;
      cyc("Gab", c, rng(1, 12), 14, 0);
      abort = 1'b0;
    end

    // start held high: back-to-back G with one IDLE cycle between
    letter = 3'd6;
    start  = 1'b1;
    @(posedge CLOCK_50);
    #1;
    for (int rep = 0; rep < 3; rep++)
      for (int c = 1; c <= 38; c++)
        cyc($sformatf("Gbb%0d", rep), c, mask_g, 37, 37);
    start = 1'b0;
    abort = 1'b1;
    @(posedge CLOCK_50);
    #1;
    abort = 1'b0;
    @(negedge CLOCK_50);
    chk("final abort busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter TICK_CYCLES, default 25_000_000, meaning: CLOCK_50 cycles per Morse unit U (0.5 s at 50 MHz); legal range is at least 1.
REQ-002 Parameter DASH_UNITS, default 3, meaning: dash on-time in units; legal range is at least 2.
REQ-003 CLOCK_50  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to transmit; level sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of the transmission in progress.
REQ-007 letter  input  3  letter select: 0=A, 1=B, 2=C, 3=D, 4=E, 5=F, 6=G, 7=H.
REQ-008 light  output  1  Morse lamp (drives LEDR[0] at top level).
REQ-009 busy  output  1  high while a transmission is in progress (ON, GAP or DONE).
REQ-010 done  output  1  one-cycle pulse when a transmission completes normally.

Function
REQ-011 Code table (first symbol listed first): A .-, B -..., C -.-., D -.., E ., F ..-., G --., H ....
REQ-012 Each table entry SHALL hold a 4-bit pattern and a 3-bit length (1..4); pattern bit i is symbol i, where 1=dash and 0=dot, and symbol 0 is sent first.
REQ-013 State machine states: IDLE, ON, GAP, DONE.
REQ-014 In IDLE with start=1 at an edge:
- latch pattern and length for letter;
- set symbol index to 0;
- load the unit counter;
- enter ON, so light=1 from the next cycle.
REQ-015 ON SHALL last exactly U cycles for a dot or DASH_UNITS*U cycles for a dash, where U=TICK_CYCLES.
REQ-016 At the end of ON:
- if more symbols remain, go to GAP (light=0 for exactly U cycles), then ON for the next symbol;
- otherwise go to DONE.
REQ-017 DONE SHALL last one cycle with done=1 and light=0, then go to IDLE.
REQ-018 busy=1 in ON, GAP and DONE; busy=0 in IDLE.
REQ-019 light=1 only in ON.
REQ-020 letter and start changes while busy=1 SHALL be ignored; the latched letter SHALL be used throughout the transmission.
REQ-021 Start held high SHALL begin a new transmission on the first IDLE cycle after DONE; this gives exactly one IDLE cycle between transmissions.
REQ-022 abort=1 in ON or GAP:
- next state is IDLE;
- light=0, busy=0;
- no done pulse.
REQ-023 abort=1 in DONE SHALL NOT suppress the done pulse already being issued; abort in IDLE has no effect and takes priority over start.
REQ-024 The unit counter width SHALL be $clog2(DASH_UNITS*TICK_CYCLES+1); the counter SHALL count down and SHALL NOT wrap within a phase.
REQ-025 The unit counter SHALL reload at every phase entry, so the first unit after start is always full length.

Reset
REQ-026 While reset=1, the block SHALL immediately (asynchronously) set state=IDLE, light=0, busy=0 and done=0, and clear the counter, symbol index and latched code.
REQ-027 Reset asserted mid-transmission SHALL abandon it with no done pulse.
REQ-028 After reset deasserts, the first start SHALL be honoured at the first clock edge.

Structure
REQ-029 Package morse_pkg SHALL hold:
- the state enum;
- the code-table type (pattern[3:0], length[2:0]);
- the A..H code table as constants;
- the DASH_UNITS default.
REQ-030 Sub-module unit_timer SHALL be a loadable down-counter with load value, load strobe and an expired flag; it is the only sub-module.

Verification (TICK_CYCLES=4, DASH_UNITS=3; cycle 1 is the first cycle after the start edge)
REQ-031 letter=0 (A), start pulse -> light=1 cycles 1-4, 0 cycles 5-8, 1 cycles 9-20; done=1 on cycle 21; busy=1 cycles 1-21.
REQ-032 letter=4 (E) -> light=1 cycles 1-4; done on cycle 5; then letter=7 (H) -> four 4-cycle on-pulses separated by 4-cycle gaps, done on cycle 29.
REQ-033 letter=2 (C) started, letter changed to 4 and start re-pulsed on cycle 6 -> C sequence unchanged (light on 1-12, 17-20, 25-36, 41-44); done on cycle 45.
REQ-034 letter=1 (B), reset asserted on cycle 7 -> light, busy and done drop to 0 without waiting for a clock edge; no done; a new start after reset sends B from cycle 1.
REQ-035 letter=6 (G), abort on cycle 14 -> IDLE on cycle 15 with light=0, busy=0 and no done; start held high constantly -> back-to-back G transmissions with exactly one IDLE cycle between each done and the next light rise.
